ram_arbiter: RTL and testbench

- Two-requester arbiter sharing one single-port, read-first synchronous RAM (1-cycle registered read, write and read of the same address in the same cycle).
- Sits between the CPU port (requester 0) and a secondary master such as DMA or display fetch (requester 1) on one side, and the RAM instance on the other.
- Round-robin arbitration with an optional bounded burst lock.
- Returns read data to the owning requester one cycle after acceptance.

---
 rtl/ram_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port read-first RAM.
// Supports bounded burst locking and routes registered read data back to its owner.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic                  last_grant;
  logic                  owner_locked;
  logic [CW-1:0]         burst_cnt;
  logic                  gnt0, gnt1, xfer, glock;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] hold0, hold1;

  assign owner_valid = last_grant ? req1_valid : req0_valid;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (owner_locked && owner_valid && (burst_cnt < MAX_CNT)) begin
        gnt0 = ~last_grant;
        gnt1 = last_grant;
      end else if (req0_valid && !req1_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid && !req0_valid) begin
        gnt1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign glock      = gnt1 ? req1_lock : (gnt0 & req0_lock);

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_we    = req0_we;
      ram_addr  = req0_addr;
      ram_wdata = req0_wdata;
    end else if (gnt1) begin
      ram_we    = req1_we;
      ram_addr  = req1_addr;
      ram_wdata = req1_wdata;
    end
  end

  // Count only continues while the same locked owner keeps winning; it saturates
  // so an uncontested lock can hold the RAM indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= 1'b1;
      owner_locked <= 1'b0;
      burst_cnt    <= '0;
    end else if (xfer) begin
      last_grant   <= gnt1;
      owner_locked <= glock;
      if ((gnt1 == last_grant) && owner_locked)
        burst_cnt <= (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + CW'(1);
      else
        burst_cnt <= CW'(1);
    end else begin
      owner_locked <= 1'b0;
      burst_cnt    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      rsp0_valid <= gnt0 & ~req0_we;
      rsp1_valid <= gnt1 & ~req1_we;
      if (rsp0_valid) hold0 <= ram_rdata;
      if (rsp1_valid) hold1 <= ram_rdata;
    end
  end

  // RAM data is live during the response cycle and frozen afterwards.
  assign rsp0_rdata = rsp0_valid ? ram_rdata : hold0;
  assign rsp1_rdata = rsp1_valid ? ram_rdata : hold1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-first RAM.
// Per-cycle vector table plus hand sequences for burst lock and reset corners.
module tb_ram_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [20:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [20:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic        ram_we;
  logic [20:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [15:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  ram_arbiter #(.ADDR_WIDTH(21), .DATA_WIDTH(16), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic v0, we0, lk0; logic [20:0] a0; logic [15:0] d0;
    logic v1, we1, lk1; logic [20:0] a1; logic [15:0] d1;
    logic r0, r1, rwe; logic [20:0] raddr; logic [15:0] rwd;
    logic s0; logic [15:0] sd0; logic s1; logic [15:0] sd1;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, we0, lk0, input logic [20:0] a0, input logic [15:0] d0,
                       input logic v1, we1, lk1, input logic [20:0] a1, input logic [15:0] d1);
    req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idle_cycles(input int n, input logic first_rsp0, input logic first_rsp1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("idle ram_we", 32'(ram_we), 0);
      check("idle ram_addr", 32'(ram_addr), 0);
      check("idle rsp0_valid", 32'(rsp0_valid), 32'((i == 0) && first_rsp0));
      check("idle rsp1_valid", 32'(rsp1_valid), 32'((i == 0) && first_rsp1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1,1,0,'h10,'hBEEF, 0,0,0,0,0,        1,0,1,'h10,'hBEEF, 0,0,       0,0};
    vecs[1]  = '{1,0,0,'h10,0,      0,0,0,0,0,        1,0,0,'h10,0,      0,0,       0,0};
    vecs[2]  = '{0,0,0,0,0,         0,0,0,0,0,        0,0,0,0,0,         1,'hBEEF,  0,0};
    vecs[3]  = '{1,1,0,1,'h1111,    0,0,0,0,0,        1,0,1,1,'h1111,    0,'hBEEF,  0,0};
    vecs[4]  = '{0,0,0,0,0,         1,1,0,2,'h2222,   0,1,1,2,'h2222,    0,'hBEEF,  0,0};
    vecs[5]  = '{1,0,0,1,0,         1,0,0,2,0,        1,0,0,1,0,         0,'hBEEF,  0,0};
    vecs[6]  = '{1,0,0,1,0,         1,0,0,2,0,        0,1,0,2,0,         1,'h1111,  0,0};
    vecs[7]  = '{1,0,0,1,0,         1,0,0,2,0,        1,0,0,1,0,         0,'h1111,  1,'h2222};
    vecs[8]  = '{1,0,0,1,0,         1,0,0,2,0,        0,1,0,2,0,         1,'h1111,  0,'h2222};
    vecs[9]  = '{0,0,0,0,0,         0,0,0,0,0,        0,0,0,0,0,         0,'h1111,  1,'h2222};
    vecs[10] = '{0,0,0,0,0,         0,0,0,0,0,        0,0,0,0,0,         0,'h1111,  0,'h2222};
    vecs[11] = '{0,0,0,0,0,         1,1,0,'h20,'hCAFE, 0,1,1,'h20,'hCAFE, 0,'h1111,  0,'h2222};
    vecs[12] = '{1,0,0,'h20,0,      0,0,0,0,0,        1,0,0,'h20,0,      0,'h1111,  0,'h2222};
    vecs[13] = '{0,0,0,0,0,         0,0,0,0,0,        0,0,0,0,0,         1,'hCAFE,  0,'h2222};

    rst_n = 1'b0;
    drive(1, 1, 0, 'h5, 'h1234, 1, 0, 0, 'h6, 0);
    #12;
    check("reset ready0", 32'(req0_ready), 0);
    check("reset ready1", 32'(req1_ready), 0);
    check("reset ram_we", 32'(ram_we), 0);
    check("reset ram_addr", 32'(ram_addr), 0);
    check("reset ram_wdata", 32'(ram_wdata), 0);
    check("reset rsp0_valid", 32'(rsp0_valid), 0);
    check("reset rsp1_valid", 32'(rsp1_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tests 1, 2, 4: single-cycle vectors, one per clock
    for (int i = 0; i < 14; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].v0, vecs[i].we0, vecs[i].lk0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].lk1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("v%0d ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
      check($sformatf("v%0d ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
      check($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vecs[i].rwe));
      check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].raddr));
      check($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].rwd));
      check($sformatf("v%0d rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].s0));
      check($sformatf("v%0d rsp0_rdata", i), 32'(rsp0_rdata), 32'(vecs[i].sd0));
      check($sformatf("v%0d rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].s1));
      check($sformatf("v%0d rsp1_rdata", i), 32'(rsp1_rdata), 32'(vecs[i].sd1));
    end

    // Test 3: req1 locked; req0 joins at cycle 2 and wins only after 8 grants
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(c >= 2, 0, 0, 1, 0, 1, 0, 1, 2, 0);
      #1;
      check($sformatf("burst c%0d ready1", c), 32'(req1_ready), 32'((c < 8) || (c == 9)));
      check($sformatf("burst c%0d ready0", c), 32'(req0_ready), 32'(c == 8));
    end

    // Test 6: idle clears lock state
    idle_cycles(5, 0, 1);

    // Uncontested lock runs past the limit; a competitor then wins at once
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      drive(c == 12, 0, 0, 1, 0, 1, 0, 1, 2, 0);
      #1;
      check($sformatf("sat c%0d ready1", c), 32'(req1_ready), 32'(c < 12));
      check($sformatf("sat c%0d ready0", c), 32'(req0_ready), 32'(c == 12));
    end
    idle_cycles(5, 1, 0);

    // Lock count restarts at 1 after the idle gap
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(c >= 3, 0, 0, 1, 0, 1, 0, 1, 2, 0);
      #1;
      check($sformatf("restart c%0d ready1", c), 32'(req1_ready), 32'(c < 8));
      check($sformatf("restart c%0d ready0", c), 32'(req0_ready), 32'(c == 8));
    end
    idle_cycles(2, 1, 0);

    // Test 5: reset while a read response is pending
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst5 ready0", 32'(req0_ready), 1);
    @(posedge clk);
    #1;
    check("rst5 rsp0 pending", 32'(rsp0_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst5 rsp0 cleared", 32'(rsp0_valid), 0);
    check("rst5 ready0 in reset", 32'(req0_ready), 0);
    check("rst5 ram_addr in reset", 32'(ram_addr), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
    #1;
    check("rst5 contended ready0", 32'(req0_ready), 1);
    check("rst5 contended ready1", 32'(req1_ready), 0);
    check("rst5 rsp0 after reset", 32'(rsp0_valid), 0);
    idle_cycles(2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
